// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer: state encodings and default tuning values.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PLAYING = 3'd1,
    ST_HIT     = 3'd2,
    ST_OVER    = 3'd3,
    ST_WON     = 3'd4
  } state_t;

  localparam int LIVES_W = 2;

  localparam logic [LIVES_W-1:0] LIVES_INIT_DEF = 2'd3;
  localparam logic [7:0]         WIN_LEVEL_DEF  = 8'd10;
  localparam logic [7:0]         HIT_TICKS_DEF  = 8'd60;
  localparam logic [7:0]         FLASH_DIV_DEF  = 8'd8;

endpackage

// File: rtl/game_state_fsm_button_sync_edge.sv
// Two-flop synchroniser for a raw active-low key, plus a one-clk pulse on its falling edge.
// Latency: press is high in the third clk after the key level is first sampled low.
// Backpressure: none; every synchronised press yields exactly one pulse.
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset
//   btn_n  in   raw active-low key, asynchronous to clk
//   press  out  one-clk pulse per key press
module button_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  logic sync1;
  logic sync2;
  logic prev;

  // Flops reset to the released level so that leaving reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign press = prev & ~sync2;

endmodule

// File: rtl/game_state_fsm.sv
// Top-level game sequencer: title -> play -> hit-freeze -> game-over/win.
// Latency: run_en is combinational from the state register (0 clk); all other outputs registered.
// Backpressure: none; game_en ticks are consumed as they arrive, start presses every clk.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   game_en         one-clk slow tick
//   start_btn_n     raw active-low start key
//   collision       collision level from the detector
//   bank_level      banked box count
//   player_height   current player height
//   run_en          gated play tick for the play modules
//   restart_pulse   one-clk pulse on game start
//   game_state      current state encoding
//   lives           remaining lives
//   hit_flash       renderer blink control
//   game_over       high in OVER
//   game_won        high in WON
module game_state_fsm
  import game_pkg::*;
#(
  parameter logic [LIVES_W-1:0] LIVES_INIT = LIVES_INIT_DEF,
  parameter logic [7:0]         WIN_LEVEL  = WIN_LEVEL_DEF,
  parameter logic [7:0]         HIT_TICKS  = HIT_TICKS_DEF,
  parameter logic [7:0]         FLASH_DIV  = FLASH_DIV_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_en,
  input  logic               start_btn_n,
  input  logic               collision,
  input  logic [7:0]         bank_level,
  input  logic [9:0]         player_height,
  output logic               run_en,
  output logic               restart_pulse,
  output logic [2:0]         game_state,
  output logic [LIVES_W-1:0] lives,
  output logic               hit_flash,
  output logic               game_over,
  output logic               game_won
);

  logic start_press;

  button_sync_edge u_start_sync (
    .clk   (clk),
    .rst   (rst),
    .btn_n (start_btn_n),
    .press (start_press)
  );

  state_t             state_q,     state_d;
  logic [LIVES_W-1:0] lives_q,     lives_d;
  logic               armed_q,     armed_d;
  logic [7:0]         timer_q,     timer_d;
  logic [7:0]         flash_cnt_q, flash_cnt_d;
  logic               hit_flash_q, hit_flash_d;
  logic               restart_q,   restart_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lives_q     <= '0;
      armed_q     <= 1'b0;
      timer_q     <= 8'd0;
      flash_cnt_q <= 8'd0;
      hit_flash_q <= 1'b0;
      restart_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      armed_q     <= armed_d;
      timer_q     <= timer_d;
      flash_cnt_q <= flash_cnt_d;
      hit_flash_q <= hit_flash_d;
      restart_q   <= restart_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    armed_d     = armed_q;
    timer_d     = timer_q;
    flash_cnt_d = flash_cnt_q;
    hit_flash_d = hit_flash_q;
    restart_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_press) begin
          state_d   = ST_PLAYING;
          lives_d   = LIVES_INIT;
          armed_d   = 1'b0;
          restart_d = 1'b1;
        end
      end

      ST_PLAYING: begin
        if (game_en) begin
          if (bank_level >= WIN_LEVEL) begin
            state_d = ST_WON;
          end else if (player_height == 10'd0) begin
            state_d = ST_OVER;
            lives_d = '0;
          end else if (collision && armed_q) begin
            // Last life (or a degenerate zero) ends the game instead of wrapping.
            if (lives_q < LIVES_W'(2)) begin
              state_d = ST_OVER;
              lives_d = '0;
            end else begin
              state_d     = ST_HIT;
              lives_d     = lives_q - LIVES_W'(1);
              timer_d     = HIT_TICKS;
              flash_cnt_d = 8'd0;
              hit_flash_d = 1'b1;
              armed_d     = 1'b0;
            end
          end else if (!collision) begin
            // Re-arm only once the player is clear, so a lingering overlap costs one life.
            armed_d = 1'b1;
          end
        end
      end

      ST_HIT: begin
        if (game_en) begin
          timer_d = timer_q - 8'd1;
          if (flash_cnt_q + 8'd1 >= FLASH_DIV) begin
            flash_cnt_d = 8'd0;
            hit_flash_d = ~hit_flash_q;
          end else begin
            flash_cnt_d = flash_cnt_q + 8'd1;
          end
          // <= 1 also rescues a zero timer rather than wrapping to 255.
          if (timer_q <= 8'd1) begin
            state_d     = ST_PLAYING;
            timer_d     = 8'd0;
            hit_flash_d = 1'b0;
          end
        end
      end

      ST_OVER, ST_WON: begin
        if (start_press) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign run_en        = game_en && (state_q == ST_PLAYING);
  assign restart_pulse = restart_q;
  assign game_state    = state_q;
  assign lives         = lives_q;
  assign hit_flash     = hit_flash_q;
  assign game_over     = (state_q == ST_OVER);
  assign game_won      = (state_q == ST_WON);

endmodule

// File: tb/tb_game_state_fsm.sv
// Self-checking bench for game_state_fsm: random and directed stimulus, reference model, scoreboard.
// Latency: expectations describe the outputs visible during the cycle the inputs are applied.
// Backpressure: n/a.
module tb_game_state_fsm;

  localparam int P_IDLE = 0, P_PLAY = 1, P_HIT = 2, P_OVER = 3, P_WON = 4;
  localparam int LIVES0 = 3, WIN = 10, HITT = 60, FDIV = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       game_en = 1'b0;
  logic       start_btn_n = 1'b1;
  logic       collision = 1'b0;
  logic [7:0] bank_level = 8'd0;
  logic [9:0] player_height = 10'd100;
  logic       run_en, restart_pulse, hit_flash, game_over, game_won;
  logic [2:0] game_state;
  logic [1:0] lives;

  game_state_fsm dut (
    .clk           (clk),
    .rst           (rst),
    .game_en       (game_en),
    .start_btn_n   (start_btn_n),
    .collision     (collision),
    .bank_level    (bank_level),
    .player_height (player_height),
    .run_en        (run_en),
    .restart_pulse (restart_pulse),
    .game_state    (game_state),
    .lives         (lives),
    .hit_flash     (hit_flash),
    .game_over     (game_over),
    .game_won      (game_won)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int lv;
    int hf;
    int rp;
    int re;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: game rules in plain terms; hit progress kept as a tick count.
  bit   m_valid = 0;
  int   m_state = P_IDLE;
  int   m_lives = 0;
  bit   m_armed = 0;
  int   m_hit_n = 0;
  bit   m_restart = 0;
  bit   past[1:3] = '{1'b1, 1'b1, 1'b1};

  task automatic chk(input string name, input logic [15:0] act, input int want);
    checks++;
    if (act !== 16'(want)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  task automatic step(input bit r, input bit ge, input bit bn, input bit c,
                      input int bank, input int h);
    exp_t e;
    bit   press;
    bit   rs_next;
    @(posedge clk);
    #1;
    rst           = r;
    game_en       = ge;
    start_btn_n   = bn;
    collision     = c;
    bank_level    = 8'(bank);
    player_height = 10'(h);

    // The key is seen through two synchroniser stages and an edge register.
    press = past[3] && !past[2];

    if (m_valid) begin
      e.st = m_state;
      e.lv = m_lives;
      e.hf = (m_state == P_HIT) ? (((m_hit_n / FDIV) % 2) == 0) : 0;
      e.rp = m_restart;
      e.re = ge && (m_state == P_PLAY);
      exp_q.push_back(e);
    end

    if (r) begin
      m_valid   = 1;
      m_state   = P_IDLE;
      m_lives   = 0;
      m_armed   = 0;
      m_hit_n   = 0;
      m_restart = 0;
      past      = '{1'b1, 1'b1, 1'b1};
    end else begin
      rs_next = 0;
      case (m_state)
        P_IDLE: if (press) begin
          m_state = P_PLAY; m_lives = LIVES0; m_armed = 0; rs_next = 1;
        end
        P_PLAY: if (ge) begin
          if (bank >= WIN) m_state = P_WON;
          else if (h == 0) begin m_state = P_OVER; m_lives = 0; end
          else if (c && m_armed) begin
            if (m_lives == 1) begin m_state = P_OVER; m_lives = 0; end
            else begin m_lives--; m_state = P_HIT; m_hit_n = 0; m_armed = 0; end
          end else if (!c) m_armed = 1;
        end
        P_HIT: if (ge) begin
          m_hit_n++;
          if (m_hit_n == HITT) m_state = P_PLAY;
        end
        default: if (press) m_state = P_IDLE;
      endcase
      m_restart = rs_next;
      past[3] = past[2];
      past[2] = past[1];
      past[1] = bn;
    end
  endtask

  // Monitor: the DUT presents its outputs every clk; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("game_state",    16'(game_state),    e.st);
        chk("lives",         16'(lives),         e.lv);
        chk("hit_flash",     16'(hit_flash),     e.hf);
        chk("restart_pulse", 16'(restart_pulse), e.rp);
        chk("run_en",        16'(run_en),        e.re);
        chk("game_over",     16'(game_over),     int'(e.st == P_OVER));
        chk("game_won",      16'(game_won),      int'(e.st == P_WON));
      end
    end
  end

  task automatic press_start(input bit ge);
    for (int i = 0; i < 3; i++) step(0, ge, 0, 0, 0, 100);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 100);
  endtask

  initial begin
    bit col = 0;
    bit bn  = 1;
    int bank, h;

    // Reset, then a long idle with ticks that must not leak through run_en.
    step(1, 0, 1, 0, 0, 100);
    step(1, 0, 1, 0, 0, 100);
    for (int i = 0; i < 100; i++) step(0, (i % 3) == 0, 1, 0, 0, 100);

    // Start with a 10-clk key hold, then a full hit/freeze cycle and two more collisions.
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 100);
    for (int i = 0; i < 6; i++)  step(0, 0, 1, 0, 0, 100);
    step(0, 1, 1, 0, 0, 100);
    for (int i = 0; i < 70; i++) step(0, 1, 1, 1, 0, 100);
    step(0, 1, 1, 0, 0, 100);
    step(0, 1, 1, 1, 0, 100);
    for (int i = 0; i < 62; i++) step(0, 1, 1, 1, 0, 100);
    step(0, 1, 1, 0, 0, 100);
    step(0, 1, 1, 1, 0, 100);
    // Over: first press returns to title, second starts a new game.
    press_start(1);
    press_start(0);

    // Win beats a simultaneous armed collision.
    step(0, 1, 1, 0, 0, 100);
    step(0, 1, 1, 1, 10, 100);
    press_start(1);
    press_start(0);

    // Height zero ends the game; then reset in the middle of a freeze.
    step(0, 1, 1, 0, 0, 0);
    press_start(0);
    press_start(0);
    step(0, 1, 1, 0, 0, 100);
    step(0, 1, 1, 1, 0, 100);
    for (int i = 0; i < 30; i++) step(0, 1, 1, 1, 0, 100);
    step(1, 1, 1, 1, 0, 100);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 100);

    // Random play.
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 7) == 0) col = ~col;
      if (bn) bn = ($urandom_range(0, 59) != 0);
      else    bn = ($urandom_range(0, 3) == 0);
      bank = ($urandom_range(0, 63) == 0) ? int'($urandom_range(10, 255))
                                          : int'($urandom_range(0, 9));
      h    = ($urandom_range(0, 199) == 0) ? 0 : int'($urandom_range(1, 1023));
      step($urandom_range(0, 1999) == 0, $urandom_range(0, 2) == 0, bn, col, bank, h);
    end

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 16'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_state_fsm.md
Name: game_state_fsm

Overview:
- Top-level game sequencer. It sits between game_clock_generator and the play modules: player_control, obstacle_control, player_height_manager and bank_control.
- Consumes the slow tick, the collision detector output, bank_level and the player's current height.
- Produces a gated play tick (run_en), a lives count, a hit-flash strobe for the renderer, and a one-cycle restart pulse.
- Implements title → play → hit-freeze → game-over/win sequencing.

Parameters:
- LIVES_INIT, 3, lives loaded on game start (1..3).
- WIN_LEVEL, 8'd10, bank_level at or above which the game is won.
- HIT_TICKS, 8'd60, game_en ticks spent frozen in HIT after a collision (1..255).
- FLASH_DIV, 8'd8, game_en ticks per hit_flash toggle (≥1).

Ports:
- clk  in  1  system clock (CLOCK_50).
- rst  in  1  synchronous, active-high reset (SW[0]).
- game_en  in  1  one-clk tick from game_clock_generator.
- start_btn_n  in  1  raw active-low start key (KEY[3]), asynchronous to clk.
- collision  in  1  level from collision_detector.
- bank_level  in  8  banked box count from bank_control.
- player_height  in  10  current player height from player_height_manager.
- run_en  out  1  gated tick; drives game_en of the play modules.
- restart_pulse  out  1  one-clk pulse; ORed with rst for the play modules.
- game_state  out  3  current state encoding.
- lives  out  2  remaining lives.
- hit_flash  out  1  renderer blink control.
- game_over  out  1  high in OVER.
- game_won  out  1  high in WON.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All state is updated on posedge clk.
- Reset values: game_state=IDLE, lives=0, hit_flash=0, restart_pulse=0, game_over=0, game_won=0, armed=0, hit timer=0, flash counter=0.
- Start key handling:
  - start_btn_n passes through a 2-flop synchroniser.
  - start_press = one-clk pulse on the synchronised falling edge.
  - start_press is evaluated every clk, not gated by game_en.
- run_en = game_en AND (game_state==PLAYING). It is combinational from registered state, so latency is 0.
- game_over = (state==OVER); game_won = (state==WON). Both are decoded from the state register.
- States: IDLE=0, PLAYING=1, HIT=2, OVER=3, WON=4. Encodings 5–7 are illegal and go to IDLE on the next clk.
- IDLE:
  - On start_press → PLAYING, with lives=LIVES_INIT, armed=0, restart_pulse=1 for exactly one clk.
- PLAYING: evaluated only on clk where game_en=1, in this priority order:
  - (1) bank_level ≥ WIN_LEVEL → WON.
  - (2) player_height==0 → OVER, with lives=0.
  - (3) collision=1 and armed=1:
    - if lives==1 → OVER, with lives=0;
    - otherwise lives decrements by 1, state → HIT, hit timer=HIT_TICKS, flash counter=0, hit_flash=1, armed=0.
  - (4) collision=0 → armed=1.
  - With collision=1 and armed=0: no action.
- HIT: run_en=0, so play modules freeze. On each game_en:
  - hit timer decrements;
  - flash counter increments; when it reaches FLASH_DIV it clears and hit_flash toggles;
  - when the timer reaches 0 (the tick that makes it 0) → PLAYING, with hit_flash=0.
  - Collisions are ignored in HIT.
  - armed stays 0, so the obstacle still overlapping the player at resume does not cost a second life.
- OVER and WON: lives holds. On start_press → IDLE. A second start_press is required to begin a new game.
- Simultaneous events:
  - start_press and game_en in the same clk: start_press wins in IDLE, OVER and WON; start_press is ignored in PLAYING and HIT.
  - Win and collision on the same tick: win wins.
- rst asserted mid-HIT or mid-PLAYING: every register returns to its reset value next clk. restart_pulse is not asserted on rst.
- Width rules:
  - lives never underflows; the decrement only happens when lives ≥2.
  - Hit timer and flash counter are 8-bit unsigned.
  - bank_level compare is unsigned 8-bit.

Decomposition:
- Shared package game_pkg holds:
  - state encodings ST_IDLE..ST_WON, 3-bit;
  - LIVES_W=2;
  - default LIVES_INIT, WIN_LEVEL, HIT_TICKS, FLASH_DIV values.
- One sub-module, button_sync_edge: 2-flop synchroniser plus falling-edge one-clk pulse, with clk/rst/btn_n in and press out. It is reused later for the other keys.

Test Plan:
- rst for 2 clk, then idle 100 clk → state=0, lives=0, run_en=0 despite game_en ticks. Drop start_btn_n for 10 clk → restart_pulse high exactly 1 clk; state=1 within 4 clk; lives=3.
- In PLAYING, collision=0 for 1 tick (arms), then collision=1 held → lives 3→2 on that tick and state=2. run_en=0 for 60 ticks; hit_flash toggles every 8 ticks. Return to state=1; lives stays 2 while collision stays 1. Drop collision for 1 tick, raise again → lives=1.
- lives=1, armed, collision tick → state=3, lives=0, game_over=1. One start press → state=0. A second press → state=1 with lives=3.
- bank_level=10 and collision=1 on the same tick with armed=1 → state=4, game_won=1, lives unchanged.
- player_height=0 on a tick in PLAYING → state=3. Assert rst mid-HIT (timer=30) → next clk state=0 and all outputs at reset values.
- Start press coincident with a game_en tick in OVER → state=0. The same press timing in PLAYING → no state change.
